mc_ctrl_seq: RTL

Parametrised multicycle control sequencer for the RV32I core. It replaces the fixed single-pass control with an explicit FETCH/DECODE/EXEC/MEM/WB state machine and adds new capabilities:
- variable-latency memory handshakes;
- wait-timeout trap;
- illegal-opcode trap;
- a HALTED state;
- a parametrised retired-instruction counter.

It sits between the instruction register and the datapath muxes and write enables.

---
 rtl/mc_pkg.sv | 75 +++++++
 rtl/mc_wait_timer.sv | 42 ++++
 rtl/mc_ctrl_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control sequencer.
// Covers opcodes, state codes, the instruction class enum and select/trap codes.
package mc_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_LUI   = 4'd0,
    CLS_AUIPC = 4'd1,
    CLS_JAL   = 4'd2,
    CLS_JALR  = 4'd3,
    CLS_BR    = 4'd4,
    CLS_LD    = 4'd5,
    CLS_ST    = 4'd6,
    CLS_OPIMM = 4'd7,
    CLS_OP    = 4'd8
  } cls_e;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JAL    = 2'd2;
  localparam logic [1:0] PC_JALR   = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IFETCH  = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  typedef struct packed {
    logic legal;
    cls_e cls;
  } dec_t;

  function automatic dec_t classify(input logic [6:0] opc);
    dec_t d;
    d.legal = 1'b1;
    d.cls   = CLS_OP;
    case (opc)
      OPC_LUI:    d.cls = CLS_LUI;
      OPC_AUIPC:  d.cls = CLS_AUIPC;
      OPC_JAL:    d.cls = CLS_JAL;
      OPC_JALR:   d.cls = CLS_JALR;
      OPC_BRANCH: d.cls = CLS_BR;
      OPC_LOAD:   d.cls = CLS_LD;
      OPC_STORE:  d.cls = CLS_ST;
      OPC_OPIMM:  d.cls = CLS_OPIMM;
      OPC_OP:     d.cls = CLS_OP;
      default:    d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Wait-state counter shared by the FETCH and MEM handshakes.
// expire flags the waiting cycle that would bring the count to WAIT_MAX.
module mc_wait_timer #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(WAIT_MAX - 1);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  // next count: clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign expire = en && (cnt_q == LAST);

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_ctrl_seq.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RV32I core,
// with memory wait timeouts, illegal-opcode trap, halt and retire counter.
module mc_ctrl_seq
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned WAIT_W   = 8,
  parameter int unsigned HALT_EN  = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0]       OPCODE,
  input  logic             I_MEM_RDY,
  input  logic             D_MEM_RDY,
  input  logic             BR_TAKEN,
  input  logic             HALT_REQ,
  output logic             I_MEM_REQ,
  output logic             IR_WE,
  output logic             D_MEM_REQ,
  output logic             D_MEM_WE,
  output logic             RF_WE,
  output logic [1:0]       WB_SEL,
  output logic             PC_WE,
  output logic [1:0]       PC_SEL,
  output logic             ALU_SRC1,
  output logic             ALU_SRC2,
  output logic [2:0]       STATE,
  output logic [CNT_W-1:0] NUM_INST,
  output logic             HALTED,
  output logic             TRAP,
  output logic [1:0]       TRAP_CAUSE
);

  state_e            state_q, state_d;
  cls_e              cls_q, cls_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  num_q, num_d;
  dec_t              dec_s;
  logic              tmr_en_s, tmr_expire_s;
  logic              i_req_s, ir_we_s, d_req_s, d_we_s, rf_we_s, pc_we_s;
  logic [1:0]        wb_sel_s, pc_sel_s;
  logic              alu1_s, alu2_s;

  assign dec_s    = classify(OPCODE);
  assign tmr_en_s = ((state_q == ST_FETCH) && !I_MEM_RDY) ||
                    ((state_q == ST_MEM)   && !D_MEM_RDY);

  mc_wait_timer #(.WAIT_MAX(WAIT_MAX), .WAIT_W(WAIT_W)) u_wait (
    .clk    (CLK),
    .rst    (RST),
    .clr    (!tmr_en_s),
    .en     (tmr_en_s),
    .expire (tmr_expire_s)
  );

  // next state, class/cause capture and Moore strobes
  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    cause_d  = cause_q;
    i_req_s  = 1'b0;
    ir_we_s  = 1'b0;
    d_req_s  = 1'b0;
    d_we_s   = 1'b0;
    rf_we_s  = 1'b0;
    pc_we_s  = 1'b0;
    wb_sel_s = WB_ALU;
    pc_sel_s = PC_PLUS4;
    alu1_s   = 1'b0;
    alu2_s   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        i_req_s = 1'b1;
        if (I_MEM_RDY) begin
          ir_we_s = 1'b1;
          state_d = ST_DECODE;
        end else if (tmr_expire_s) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IFETCH;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        cls_d = dec_s.cls;
        // halt wins over the illegal-opcode check
        if ((HALT_EN != 0) && HALT_REQ) begin
          state_d = ST_HALTED;
        end else if (!dec_s.legal) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu1_s = (cls_q == CLS_AUIPC) || (cls_q == CLS_JAL);
        alu2_s = !((cls_q == CLS_OP) || (cls_q == CLS_BR));
        if (cls_q == CLS_BR) begin
          pc_we_s  = 1'b1;
          pc_sel_s = BR_TAKEN ? PC_BRANCH : PC_PLUS4;
          state_d  = ST_FETCH;
        end else if ((cls_q == CLS_LD) || (cls_q == CLS_ST)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        d_req_s = 1'b1;
        d_we_s  = (cls_q == CLS_ST);
        if (D_MEM_RDY) begin
          if (cls_q == CLS_ST) begin
            pc_we_s = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (tmr_expire_s) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DMEM;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        rf_we_s = 1'b1;
        pc_we_s = 1'b1;
        state_d = ST_FETCH;
        case (cls_q)
          CLS_LD:   wb_sel_s = WB_MEM;
          CLS_JAL:  begin wb_sel_s = WB_PC4; pc_sel_s = PC_JAL;  end
          CLS_JALR: begin wb_sel_s = WB_PC4; pc_sel_s = PC_JALR; end
          default:  wb_sel_s = WB_ALU;
        endcase
      end
      ST_HALTED: state_d = ST_HALTED;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_FETCH;
    endcase
    num_d = num_q + {{(CNT_W-1){1'b0}}, pc_we_s};
  end

  // sequencer registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_FETCH;
      cls_q   <= CLS_OP;
      cause_q <= CAUSE_NONE;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cause_q <= cause_d;
      num_q   <= num_d;
    end
  end

  assign I_MEM_REQ  = i_req_s & ~RST;
  assign IR_WE      = ir_we_s & ~RST;
  assign D_MEM_REQ  = d_req_s & ~RST;
  assign D_MEM_WE   = d_we_s  & ~RST;
  assign RF_WE      = rf_we_s & ~RST;
  assign PC_WE      = pc_we_s & ~RST;
  assign WB_SEL     = wb_sel_s;
  assign PC_SEL     = pc_sel_s;
  assign ALU_SRC1   = alu1_s;
  assign ALU_SRC2   = alu2_s;
  assign STATE      = state_q;
  assign NUM_INST   = num_q;
  assign HALTED     = (state_q == ST_HALTED);
  assign TRAP       = (state_q == ST_TRAP);
  assign TRAP_CAUSE = cause_q;

endmodule
